// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Brief    : Register-map offsets and CTRL bit positions for multi_channel_timer.
// Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

    localparam int CTRL_OFS   = 0;
    localparam int PERIOD_OFS = 1;
    localparam int COUNT_OFS  = 2;

    localparam int EN_BIT    = 0;
    localparam int AUTO_BIT  = 1;
    localparam int IRQEN_BIT = 2;

    localparam int CH_STRIDE = 4;

endpackage
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ============================================================================
// Module   : timer_channel
// Brief    : One timer channel: CTRL/PERIOD registers, tick counter, event pulse.
// Revision : 1.0 - initial release
// ============================================================================
module timer_channel
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_ctrl_we,
    input  logic       i_period_we,
    input  logic [7:0] i_wdata,
    output logic [2:0] o_ctrl,
    output logic [7:0] o_period,
    output logic [7:0] o_count,
    output logic       o_evt
);

    logic [2:0] r_ctrl;
    logic [7:0] r_period;
    logic [7:0] r_count;
    logic       w_wr;
    logic       w_last;
    logic       w_evt;

    assign w_wr   = i_ctrl_we | i_period_we;
    assign w_last = (r_period != 8'd0) && (r_count == r_period - 8'd1);
    // A register write restarts the channel, so it overrides a coinciding event.
    assign w_evt  = i_tick && r_ctrl[EN_BIT] && w_last && !w_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl   <= 3'd0;
            r_period <= 8'd0;
            r_count  <= 8'd0;
        end else begin
            if (i_ctrl_we)
                r_ctrl <= i_wdata[2:0];
            else if (w_evt && !r_ctrl[AUTO_BIT])
                r_ctrl[EN_BIT] <= 1'b0;

            if (i_period_we)
                r_period <= i_wdata;

            if (w_wr || w_evt)
                r_count <= 8'd0;
            else if (i_tick && r_ctrl[EN_BIT] && (r_period != 8'd0))
                r_count <= r_count + 8'd1;
        end
    end

    assign o_ctrl   = r_ctrl;
    assign o_period = r_period;
    assign o_count  = r_count;
    assign o_evt    = w_evt;

endmodule
`default_nettype wire

// File: rtl/multi_channel_timer.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_timer
// Brief    : Bus-mapped N-channel timer with shared prescaler, W1C PENDING and IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_timer
    import timer_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hF0,
    parameter int         NUM_CH    = 2,
    parameter int         CLK_DIV   = 50000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] BUS_ADDR,
    inout  wire  [7:0] BUS_DATA,
    input  logic       BUS_WE,
    output logic       IRQ_RAISE,
    input  logic       IRQ_ACK
);

    localparam int c_presc_w  = $clog2(CLK_DIV);
    localparam int c_pend_ofs = CH_STRIDE * NUM_CH;

    logic [c_presc_w-1:0] r_presc;
    logic                 w_tick;

    logic [8:0]        w_offset;
    logic              w_in_range;
    logic              w_is_pend;
    logic              w_is_chan;
    logic [1:0]        w_ch;
    logic [1:0]        w_reg;

    logic [2:0]        w_ctrl   [NUM_CH];
    logic [7:0]        w_period [NUM_CH];
    logic [7:0]        w_count  [NUM_CH];
    logic [NUM_CH-1:0] w_evt;
    logic [NUM_CH-1:0] w_irq_en;
    logic [NUM_CH-1:0] w_clr;

    logic [NUM_CH-1:0] r_pending;
    logic              r_irq;
    logic              r_rd_valid;
    logic [7:0]        r_rd_data;
    logic [7:0]        w_rd_data;

    assign w_tick = (r_presc == c_presc_w'(CLK_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RESET || w_tick)
            r_presc <= '0;
        else
            r_presc <= r_presc + 1'b1;
    end

    // 9-bit difference: addresses below BASE_ADDR wrap to large values.
    assign w_offset   = {1'b0, BUS_ADDR} - {1'b0, BASE_ADDR};
    assign w_in_range = (w_offset <= 9'(c_pend_ofs));
    assign w_is_pend  = (w_offset == 9'(c_pend_ofs));
    assign w_is_chan  = (w_offset <  9'(c_pend_ofs));
    assign w_ch       = w_offset[3:2];
    assign w_reg      = w_offset[1:0];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic w_sel;
        assign w_sel = BUS_WE && w_is_chan && (w_ch == 2'(g));

        timer_channel u_channel (
            .clk         (CLK),
            .rst         (RESET),
            .i_tick      (w_tick),
            .i_ctrl_we   (w_sel && (w_reg == 2'(CTRL_OFS))),
            .i_period_we (w_sel && (w_reg == 2'(PERIOD_OFS))),
            .i_wdata     (BUS_DATA),
            .o_ctrl      (w_ctrl[g]),
            .o_period    (w_period[g]),
            .o_count     (w_count[g]),
            .o_evt       (w_evt[g])
        );

        assign w_irq_en[g] = w_ctrl[g][IRQEN_BIT];
    end

    always_comb begin
        w_rd_data = 8'h00;
        if (w_is_pend) begin
            w_rd_data = 8'(r_pending);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_is_chan && (w_ch == 2'(i))) begin
                    case (w_reg)
                        2'(CTRL_OFS):   w_rd_data = {5'd0, w_ctrl[i]};
                        2'(PERIOD_OFS): w_rd_data = w_period[i];
                        2'(COUNT_OFS):  w_rd_data = w_count[i];
                        default:        w_rd_data = 8'h00;
                    endcase
                end
            end
        end
    end

    assign w_clr = (BUS_WE && w_is_pend) ? BUS_DATA[NUM_CH-1:0] : '0;

    // Set beats clear on PENDING, and a new event beats the acknowledge on IRQ.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pending  <= '0;
            r_irq      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'h00;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_evt;
            if (|(w_evt & w_irq_en))
                r_irq <= 1'b1;
            else if (IRQ_ACK)
                r_irq <= 1'b0;
            r_rd_valid <= !BUS_WE && w_in_range;
            if (!BUS_WE && w_in_range)
                r_rd_data <= w_rd_data;
        end
    end

    assign BUS_DATA  = r_rd_valid ? r_rd_data : 8'hzz;
    assign IRQ_RAISE = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_channel_timer
// Brief    : Self-checking bench for multi_channel_timer (NUM_CH=2, CLK_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_channel_timer;

    localparam logic [7:0] BASE = 8'hF0;
    localparam int         NCH  = 2;
    localparam int         DIV  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] addr = 8'h00;
    logic       we = 1'b0;
    logic       ack = 1'b0;
    logic       irq;
    logic       tb_oe = 1'b1;
    logic [7:0] tb_drv = 8'h00;
    wire  [7:0] bus_data;

    int n_tests = 0;
    int n_fail  = 0;

    assign bus_data = tb_oe ? tb_drv : 8'hzz;

    always #5 clk = ~clk;

    multi_channel_timer #(.BASE_ADDR(BASE), .NUM_CH(NCH), .CLK_DIV(DIV)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .BUS_ADDR  (addr),
        .BUS_DATA  (bus_data),
        .BUS_WE    (we),
        .IRQ_RAISE (irq),
        .IRQ_ACK   (ack)
    );

    // Reference model: register file plus tick counter, stepped once per clock.
    int         m_presc = 0;
    logic [7:0] m_ctrl   [NCH];
    logic [7:0] m_period [NCH];
    logic [7:0] m_count  [NCH];
    logic [7:0] m_pend = 8'h00;
    logic       m_irq = 1'b0;
    logic       m_rdv = 1'b0;
    logic [7:0] m_rdd = 8'h00;

    function automatic logic [7:0] m_read(input int off);
        if (off == 4 * NCH) return m_pend;
        if (off < 0 || off > 4 * NCH) return 8'h00;
        case (off % 4)
            0:       return m_ctrl[off / 4];
            1:       return m_period[off / 4];
            2:       return m_count[off / 4];
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit m_fire_soon();
        bit hit = 0;
        for (int c = 0; c < NCH; c++)
            if (m_presc == DIV - 1 && m_ctrl[c][0] && m_ctrl[c][2] && m_period[c] != 0 &&
                int'(m_count[c]) + 1 == int'(m_period[c]))
                hit = 1;
        return hit;
    endfunction

    task automatic model_step(input bit r, input logic [7:0] a, input bit w,
                              input logic [7:0] d, input bit k);
        bit         tick;
        int         off;
        bit         inr;
        bit         irq_hit;
        logic [7:0] fired;
        logic [7:0] rd;
        if (r) begin
            m_presc = 0;
            for (int c = 0; c < NCH; c++) begin
                m_ctrl[c] = 0; m_period[c] = 0; m_count[c] = 0;
            end
            m_pend = 0; m_irq = 0; m_rdv = 0; m_rdd = 0;
            return;
        end
        tick    = (m_presc == DIV - 1);
        off     = int'(a) - int'(BASE);
        inr     = (off >= 0) && (off <= 4 * NCH);
        rd      = m_read(off);
        fired   = 8'h00;
        irq_hit = 0;
        for (int c = 0; c < NCH; c++) begin
            bit wc = w && inr && (off == 4 * c);
            bit wp = w && inr && (off == 4 * c + 1);
            if (wc || wp) begin
                if (wc) m_ctrl[c] = d & 8'h07;
                if (wp) m_period[c] = d;
                m_count[c] = 0;
            end else if (tick && m_ctrl[c][0] && m_period[c] != 0) begin
                if (int'(m_count[c]) + 1 == int'(m_period[c])) begin
                    fired[c] = 1'b1;
                    if (m_ctrl[c][2]) irq_hit = 1;
                    if (!m_ctrl[c][1]) m_ctrl[c][0] = 1'b0;
                    m_count[c] = 0;
                end else begin
                    m_count[c] = m_count[c] + 8'd1;
                end
            end
        end
        if (w && off == 4 * NCH) m_pend = m_pend & ~(d & 8'h03);
        m_pend = m_pend | fired;
        if (irq_hit) m_irq = 1;
        else if (k)  m_irq = 0;
        m_rdv = !w && inr;
        if (m_rdv) m_rdd = rd;
        m_presc = (m_presc + 1) % DIV;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle; the bench drives BUS_DATA whenever the DUT should not.
    task automatic do_cycle(input bit r, input logic [7:0] a, input bit w,
                            input logic [7:0] d, input bit k);
        @(negedge clk);
        rst = r; addr = a; we = w; ack = k;
        tb_drv = w ? d : 8'($urandom);
        model_step(r, a, w, d, k);
        @(posedge clk);
        tb_oe = !m_rdv;
        #1;
        check8("bus", bus_data, m_rdv ? m_rdd : tb_drv);
        check8("irq", {7'd0, irq}, {7'd0, m_irq});
    endtask

    task automatic idle(input int n);
        repeat (n) do_cycle(0, 8'h00, 0, 8'h00, 0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        if (m_rdv) idle(1);
        do_cycle(0, a, 1, d, 0);
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp, input string name);
        do_cycle(0, a, 0, 8'h00, 0);
        check8(name, bus_data, exp);
    endtask

    typedef struct {
        logic [7:0] addr;
        bit         we;
        logic [7:0] data;
        bit         ack;
        bit         chk;
        logic [7:0] exp;
        int         post_idle;
    } vec_t;

    vec_t vecs[$];

    task automatic run_vecs();
        foreach (vecs[i]) begin
            if (vecs[i].we)
                wr(vecs[i].addr, vecs[i].data);
            else if (vecs[i].ack)
                do_cycle(0, 8'h00, 0, 8'h00, 1);
            else if (vecs[i].chk)
                rd_chk(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_rd_%h", i, vecs[i].addr));
            idle(vecs[i].post_idle);
        end
        vecs.delete();
    endtask

    initial begin
        bit         found;
        bit         r, w, k;
        logic [7:0] a, d;

        do_cycle(1, 8'h00, 0, 8'h00, 0);
        do_cycle(1, 8'h00, 0, 8'h00, 0);
        check8("reset_irq", {7'd0, irq}, 8'h00);

        // Reset readback, then channel 0 auto-reload with IRQ.
        for (int i = 0; i <= 4 * NCH; i++)
            vecs.push_back('{8'(BASE + 8'(i)), 0, 8'h00, 0, 1, 8'h00, 0});
        vecs.push_back('{8'hF1, 1, 8'h03, 0, 0, 8'h00, 0});
        vecs.push_back('{8'hF0, 1, 8'h07, 0, 0, 8'h00, 14});
        vecs.push_back('{8'hF8, 0, 8'h00, 0, 1, 8'h01, 0});
        run_vecs();

        check8("irq_after_event", {7'd0, irq}, 8'h01);
        wr(8'hF0, 8'h06);
        do_cycle(0, 8'h00, 0, 8'h00, 1);
        check8("irq_after_ack", {7'd0, irq}, 8'h00);
        rd_chk(8'hF8, 8'h01, "pend_kept_by_ack");
        wr(8'hF8, 8'h01);
        rd_chk(8'hF8, 8'h00, "pend_w1c");

        // Channel 1 one-shot.
        vecs.push_back('{8'hF5, 1, 8'h02, 0, 0, 8'h00, 0});
        vecs.push_back('{8'hF4, 1, 8'h05, 0, 0, 8'h00, 12});
        vecs.push_back('{8'hF4, 0, 8'h00, 0, 1, 8'h04, 0});
        vecs.push_back('{8'hF6, 0, 8'h00, 0, 1, 8'h00, 0});
        vecs.push_back('{8'hF8, 0, 8'h00, 0, 1, 8'h02, 0});
        vecs.push_back('{8'hF8, 1, 8'h02, 0, 0, 8'h00, 20});
        vecs.push_back('{8'hF8, 0, 8'h00, 0, 1, 8'h00, 0});
        vecs.push_back('{8'hF6, 0, 8'h00, 0, 1, 8'h00, 0});
        vecs.push_back('{8'h00, 0, 8'h00, 1, 0, 8'h00, 0});
        run_vecs();

        // Both channels aligned to the same ticks; ack lands on an event edge.
        wr(8'hF1, 8'h02);
        wr(8'hF5, 8'h02);
        for (int i = 0; i < DIV && m_presc != 0; i++) idle(1);
        wr(8'hF0, 8'h07);
        wr(8'hF4, 8'h07);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_fire_soon()) begin
                do_cycle(0, 8'h00, 0, 8'h00, 1);
                check8("ack_vs_event", {7'd0, irq}, 8'h01);
                found = 1;
            end else begin
                idle(1);
            end
        end
        if (!found) begin
            n_tests++; n_fail++;
            $display("FAIL ack_vs_event: no event within 40 cycles, got none expected one");
        end
        rd_chk(8'hF8, 8'h03, "same_tick_pend");
        wr(8'hF0, 8'h00);
        wr(8'hF4, 8'h00);
        do_cycle(0, 8'h00, 0, 8'h00, 1);
        wr(8'hF8, 8'h03);

        // PERIOD=0 never fires; PERIOD write restarts the count.
        vecs.push_back('{8'hF1, 1, 8'h00, 0, 0, 8'h00, 0});
        vecs.push_back('{8'hF0, 1, 8'h01, 0, 0, 8'h00, 40});
        vecs.push_back('{8'hF2, 0, 8'h00, 0, 1, 8'h00, 0});
        vecs.push_back('{8'hF8, 0, 8'h00, 0, 1, 8'h00, 0});
        vecs.push_back('{8'hF0, 0, 8'h00, 0, 1, 8'h01, 0});
        vecs.push_back('{8'hF1, 1, 8'h05, 0, 0, 8'h00, 10});
        vecs.push_back('{8'hF1, 1, 8'h05, 0, 0, 8'h00, 0});
        vecs.push_back('{8'hF2, 0, 8'h00, 0, 1, 8'h00, 0});
        vecs.push_back('{8'hF5, 1, 8'h01, 0, 0, 8'h00, 0});
        vecs.push_back('{8'hF4, 1, 8'h05, 0, 0, 8'h00, 6});
        run_vecs();

        // Reset during a read response with the IRQ raised.
        check8("irq_before_reset", {7'd0, irq}, 8'h01);
        do_cycle(0, 8'hF2, 0, 8'h00, 0);
        do_cycle(1, 8'h00, 0, 8'h00, 0);
        check8("rst_bus_release", bus_data, tb_drv);
        check8("rst_irq", {7'd0, irq}, 8'h00);
        for (int i = 0; i <= 4 * NCH; i++)
            rd_chk(8'(BASE + 8'(i)), 8'h00, "rst_readback");

        // Randomised traffic against the model.
        for (int i = 0; i < 500; i++) begin
            r = ($urandom_range(0, 199) == 0);
            k = ($urandom_range(0, 9) == 0);
            a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(8'hF0 + $urandom_range(0, 9));
            w = ($urandom_range(0, 2) == 0) && !m_rdv;
            if (a == 8'hF1 || a == 8'hF5) d = 8'($urandom_range(0, 4));
            else                          d = 8'($urandom);
            if (!w && $urandom_range(0, 2) == 0) a = 8'h00;
            do_cycle(r, a, w, d, k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
